// File: rtl/rv_multicycle_ctrl_pkg.sv
// rv_ctrl_pkg: shared types and encodings for the RV32I multi-cycle controller.
//   state_e    - FSM state encoding (also visible on the debug state output)
//   Op*        - RV32I major opcodes recognised by the controller
//   alu_sel_e  - ALU operation select
//   imm_sel_e  - immediate format select
//   wb_sel_e   - register-file writeback source
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluCopyB = 4'd10
    } alu_sel_e;

    typedef enum logic [2:0] {
        ImmI = 3'd0,
        ImmS = 3'd1,
        ImmB = 3'd2,
        ImmU = 3'd3,
        ImmJ = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        WbMem = 2'd0,
        WbAlu = 2'd1,
        WbPc4 = 2'd2
    } wb_sel_e;

    function automatic logic opcode_is_legal(input logic [6:0] op);
        case (op)
            OpR, OpImm, OpLoad, OpStore, OpBranch,
            OpJal, OpJalr, OpLui, OpAuipc: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// rv_multicycle_ctrl_if: bundle between the multi-cycle controller and the
// datapath/memory side.
//   Inputs to the controller : mem_rdata, mem_ready, br_eq, br_lt
//   Outputs of the controller: mem_req, mem_rw, inst, A_sel, B_sel, imm_sel,
//                              alu_sel, br_un, pc_sel, pc_we, reg_we, wb_sel,
//                              state, illegal
//   master = controller, slave = datapath/memory.
interface rv_multicycle_ctrl_if;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        br_eq;
    logic        br_lt;
    logic        mem_req;
    logic        mem_rw;
    logic [31:0] inst;
    logic        A_sel;
    logic        B_sel;
    logic [2:0]  imm_sel;
    logic [3:0]  alu_sel;
    logic        br_un;
    logic        pc_sel;
    logic        pc_we;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        illegal;

    modport master (
        input  mem_rdata, mem_ready, br_eq, br_lt,
        output mem_req, mem_rw, inst, A_sel, B_sel, imm_sel, alu_sel, br_un,
               pc_sel, pc_we, reg_we, wb_sel, state, illegal
    );

    modport slave (
        output mem_rdata, mem_ready, br_eq, br_lt,
        input  mem_req, mem_rw, inst, A_sel, B_sel, imm_sel, alu_sel, br_un,
               pc_sel, pc_we, reg_we, wb_sel, state, illegal
    );
endinterface

// File: rtl/rv_multicycle_ctrl_alu_dec.sv
// rv_alu_dec: combinational ALU operation decode.
//   i_opcode   - IR[6:0]
//   i_funct3   - IR[14:12]
//   i_funct7_5 - IR[30]
//   o_alu_sel  - ALU operation
module rv_alu_dec
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output alu_sel_e   o_alu_sel
);

    always_comb begin
        o_alu_sel = AluAdd;
        if (i_opcode == OpR || i_opcode == OpImm) begin
            case (i_funct3)
                // IR[30] means SUB only for register ops; ADDI ignores it.
                3'b000:  o_alu_sel = (i_opcode == OpR && i_funct7_5) ? AluSub : AluAdd;
                3'b001:  o_alu_sel = AluSll;
                3'b010:  o_alu_sel = AluSlt;
                3'b011:  o_alu_sel = AluSltu;
                3'b100:  o_alu_sel = AluXor;
                3'b101:  o_alu_sel = i_funct7_5 ? AluSra : AluSrl;
                3'b110:  o_alu_sel = AluOr;
                default: o_alu_sel = AluAnd;
            endcase
        end else if (i_opcode == OpLui) begin
            o_alu_sel = AluCopyB;
        end
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Holds the instruction register and drives all datapath selects and strobes.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - controller side (master) of rv_multicycle_ctrl_if
// Datapath selects are decoded from IR in every state so they stay stable from
// EXEC through MEM and WB; strobes are qualified by state.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_IR    = 32'h0000_0013,
    parameter bit          TRAP_STICKY = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    rv_multicycle_ctrl_if.master bus
);

    state_e      r_state, w_state_next;
    logic [31:0] r_ir, w_ir_next;
    logic        r_taken, w_taken_next;
    logic        r_illegal, w_illegal_next;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    alu_sel_e    w_alu_sel;
    imm_sel_e    w_imm_sel;
    wb_sel_e     w_wb_sel;
    logic        w_a_sel, w_b_sel;
    logic        w_is_mem, w_is_store, w_is_branch, w_is_jump, w_writes_rd;
    logic        w_br_cond;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];

    rv_alu_dec u_alu_dec (
        .i_opcode   (w_opcode),
        .i_funct3   (w_funct3),
        .i_funct7_5 (r_ir[30]),
        .o_alu_sel  (w_alu_sel)
    );

    // Opcode class decode
    always_comb begin
        w_a_sel     = 1'b0;
        w_b_sel     = 1'b0;
        w_imm_sel   = ImmI;
        w_wb_sel    = WbAlu;
        w_is_mem    = 1'b0;
        w_is_store  = 1'b0;
        w_is_branch = 1'b0;
        w_is_jump   = 1'b0;
        w_writes_rd = 1'b0;
        case (w_opcode)
            OpR: w_writes_rd = 1'b1;
            OpImm: begin
                w_b_sel     = 1'b1;
                w_writes_rd = 1'b1;
            end
            OpLoad: begin
                w_b_sel     = 1'b1;
                w_is_mem    = 1'b1;
                w_writes_rd = 1'b1;
                w_wb_sel    = WbMem;
            end
            OpStore: begin
                w_b_sel    = 1'b1;
                w_imm_sel  = ImmS;
                w_is_mem   = 1'b1;
                w_is_store = 1'b1;
            end
            OpBranch: begin
                w_a_sel     = 1'b1;
                w_b_sel     = 1'b1;
                w_imm_sel   = ImmB;
                w_is_branch = 1'b1;
            end
            OpJal: begin
                w_a_sel     = 1'b1;
                w_b_sel     = 1'b1;
                w_imm_sel   = ImmJ;
                w_is_jump   = 1'b1;
                w_writes_rd = 1'b1;
                w_wb_sel    = WbPc4;
            end
            OpJalr: begin
                w_b_sel     = 1'b1;
                w_is_jump   = 1'b1;
                w_writes_rd = 1'b1;
                w_wb_sel    = WbPc4;
            end
            OpLui: begin
                w_b_sel     = 1'b1;
                w_imm_sel   = ImmU;
                w_writes_rd = 1'b1;
            end
            OpAuipc: begin
                w_a_sel     = 1'b1;
                w_b_sel     = 1'b1;
                w_imm_sel   = ImmU;
                w_writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch outcome; funct3[1] selects unsigned compare on the comparator side.
    always_comb begin
        case (w_funct3)
            3'b000:  w_br_cond = bus.br_eq;
            3'b001:  w_br_cond = ~bus.br_eq;
            3'b100:  w_br_cond = bus.br_lt;
            3'b101:  w_br_cond = ~bus.br_lt;
            3'b110:  w_br_cond = bus.br_lt;
            3'b111:  w_br_cond = ~bus.br_lt;
            default: w_br_cond = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_ir_next      = r_ir;
        w_taken_next   = r_taken;
        w_illegal_next = r_illegal;
        unique case (r_state)
            StFetch: begin
                if (bus.mem_ready) begin
                    w_ir_next    = bus.mem_rdata;
                    w_state_next = StDecode;
                end
            end
            StDecode: begin
                if (opcode_is_legal(w_opcode)) begin
                    w_illegal_next = 1'b0;
                    w_state_next   = StExec;
                end else begin
                    w_illegal_next = 1'b1;
                    w_state_next   = StTrap;
                end
            end
            StExec: begin
                w_taken_next = w_is_branch & w_br_cond;
                w_state_next = w_is_mem ? StMem : StWb;
            end
            StMem: begin
                if (bus.mem_ready) begin
                    w_state_next = StWb;
                end
            end
            StWb: w_state_next = StFetch;
            StTrap: begin
                if (!TRAP_STICKY) begin
                    w_state_next = StFetch;
                end
            end
            default: w_state_next = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StFetch;
            r_ir      <= RESET_IR;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ir      <= w_ir_next;
            r_taken   <= w_taken_next;
            r_illegal <= w_illegal_next;
        end
    end

    // Strobes are gated by rst because reset parks the FSM in FETCH, which
    // would otherwise raise mem_req while reset is still held.
    always_comb begin
        bus.mem_req = ~rst & ((r_state == StFetch) | (r_state == StMem));
        bus.mem_rw  = (r_state == StMem) & w_is_store;
        bus.pc_we   = ~rst & (r_state == StWb);
        bus.reg_we  = ~rst & (r_state == StWb) & w_writes_rd;
        bus.pc_sel  = (r_state == StWb) & (w_is_jump | (w_is_branch & r_taken));
        bus.inst    = r_ir;
        bus.A_sel   = w_a_sel;
        bus.B_sel   = w_b_sel;
        bus.imm_sel = w_imm_sel;
        bus.alu_sel = w_alu_sel;
        bus.br_un   = r_ir[13];
        bus.wb_sel  = w_wb_sel;
        bus.state   = r_state;
        bus.illegal = r_illegal;
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Testbench for rv_multicycle_ctrl: directed instruction sequence with a
// writeback scoreboard (expected WB strobes queued per instruction, popped when
// pc_we is seen).
module tb_rv_multicycle_ctrl;
    import rv_ctrl_pkg::*;

    typedef struct packed {
        logic       pc_sel;
        logic       reg_we;
        logic [1:0] wb_sel;
    } wb_exp_t;

    logic    clk;
    logic    rst;
    int      checks;
    int      failures;
    wb_exp_t exp_q[$];
    wb_exp_t mon_e;

    rv_multicycle_ctrl_if bus ();

    rv_multicycle_ctrl #(
        .RESET_IR    (32'h0000_0013),
        .TRAP_STICKY (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every WB strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.pc_we === 1'b1) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("wb_pc_sel", bus.pc_sel, mon_e.pc_sel);
                chk("wb_reg_we", bus.reg_we, mon_e.reg_we);
                chk("wb_wb_sel", bus.wb_sel, mon_e.wb_sel);
            end else begin
                chk("unexpected_pc_we", bus.pc_we, 1'b0);
            end
        end else if (bus.reg_we === 1'b1) begin
            chk("stray_reg_we", bus.reg_we, 1'b0);
        end
    end

    // Runs one instruction from FETCH back to FETCH; mem_ready is driven high
    // during DECODE/EXEC to show it is ignored there.
    task automatic run_instr(input string tag, input logic [31:0] instr, input int waits,
                             input logic eq, input logic lt, input logic a, input logic b,
                             input logic [2:0] imm, input logic [3:0] alu, input logic is_mem,
                             input logic rw, input logic psel, input logic rwe,
                             input logic [1:0] wb);
        int cyc;
        wb_exp_t e;
        cyc = 0;
        e.pc_sel = psel;
        e.reg_we = rwe;
        e.wb_sel = wb;
        exp_q.push_back(e);
        bus.mem_rdata = instr;
        bus.mem_ready = 1'b1;
        bus.br_eq     = eq;
        bus.br_lt     = lt;
        #1;
        chk({tag, "_fetch_state"}, bus.state, StFetch);
        chk({tag, "_fetch_req"}, bus.mem_req, 1'b1);
        chk({tag, "_fetch_rw"}, bus.mem_rw, 1'b0);
        tick(); cyc++;
        bus.mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk({tag, "_decode_state"}, bus.state, StDecode);
        chk({tag, "_ir"}, bus.inst, instr);
        tick(); cyc++;
        chk({tag, "_exec_state"}, bus.state, StExec);
        chk({tag, "_illegal"}, bus.illegal, 1'b0);
        chk({tag, "_a_sel"}, bus.A_sel, a);
        chk({tag, "_b_sel"}, bus.B_sel, b);
        chk({tag, "_imm_sel"}, bus.imm_sel, imm);
        chk({tag, "_alu_sel"}, bus.alu_sel, alu);
        chk({tag, "_br_un"}, bus.br_un, instr[13]);
        chk({tag, "_exec_req"}, bus.mem_req, 1'b0);
        bus.mem_ready = 1'b0;
        tick(); cyc++;
        if (is_mem) begin
            for (int w = 0; w < waits; w++) begin
                chk({tag, "_mem_state"}, bus.state, StMem);
                chk({tag, "_mem_req"}, bus.mem_req, 1'b1);
                chk({tag, "_mem_rw"}, bus.mem_rw, rw);
                chk({tag, "_mem_alu_sel"}, bus.alu_sel, alu);
                tick(); cyc++;
            end
            bus.mem_ready = 1'b1;
            #1;
            chk({tag, "_mem_state"}, bus.state, StMem);
            chk({tag, "_mem_req"}, bus.mem_req, 1'b1);
            chk({tag, "_mem_rw"}, bus.mem_rw, rw);
            tick(); cyc++;
            bus.mem_ready = 1'b0;
        end
        chk({tag, "_wb_state"}, bus.state, StWb);
        chk({tag, "_wb_pc_we"}, bus.pc_we, 1'b1);
        chk({tag, "_wb_req"}, bus.mem_req, 1'b0);
        tick(); cyc++;
        chk({tag, "_done_state"}, bus.state, StFetch);
        chk({tag, "_cycles"}, cyc, is_mem ? 5 + waits : 4);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.mem_rdata = 32'h0;
        bus.mem_ready = 1'b0;
        bus.br_eq     = 1'b0;
        bus.br_lt     = 1'b0;
        tick();
        tick();
        chk("rst_state", bus.state, StFetch);
        chk("rst_ir", bus.inst, 32'h0000_0013);
        chk("rst_illegal", bus.illegal, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_pc_we", bus.pc_we, 1'b0);
        chk("rst_reg_we", bus.reg_we, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_req", bus.mem_req, 1'b1);

        //        tag       instr         wt eq lt A  B  imm   alu       mem rw psel rwe wb
        run_instr("addi",  32'h00500093, 0, 0, 0, 0, 1, ImmI, AluAdd,   0, 0, 0, 1, WbAlu);
        run_instr("lw",    32'h0040A103, 3, 0, 0, 0, 1, ImmI, AluAdd,   1, 0, 0, 1, WbMem);
        run_instr("beq_t", 32'h00208463, 0, 1, 0, 1, 1, ImmB, AluAdd,   0, 0, 1, 0, WbAlu);
        run_instr("beq_n", 32'h00208463, 0, 0, 0, 1, 1, ImmB, AluAdd,   0, 0, 0, 0, WbAlu);
        run_instr("jal",   32'h008000EF, 0, 0, 0, 1, 1, ImmJ, AluAdd,   0, 0, 1, 1, WbPc4);
        run_instr("sw",    32'h0020A223, 0, 0, 0, 0, 1, ImmS, AluAdd,   1, 1, 0, 0, WbAlu);
        run_instr("sub",   32'h40208033, 0, 0, 0, 0, 0, ImmI, AluSub,   0, 0, 0, 1, WbAlu);
        run_instr("srai",  32'h4030D093, 0, 0, 0, 0, 1, ImmI, AluSra,   0, 0, 0, 1, WbAlu);
        run_instr("addi_n",32'hC0000093, 0, 0, 0, 0, 1, ImmI, AluAdd,   0, 0, 0, 1, WbAlu);
        run_instr("lui",   32'h123450B7, 0, 0, 0, 0, 1, ImmU, AluCopyB, 0, 0, 0, 1, WbAlu);
        run_instr("auipc", 32'h00001097, 0, 0, 0, 1, 1, ImmU, AluAdd,   0, 0, 0, 1, WbAlu);
        run_instr("jalr",  32'h000080E7, 0, 0, 0, 0, 1, ImmI, AluAdd,   0, 0, 1, 1, WbPc4);
        run_instr("bltu",  32'h0020E463, 0, 0, 1, 1, 1, ImmB, AluAdd,   0, 0, 1, 0, WbAlu);
        run_instr("bge",   32'h0020D463, 0, 0, 1, 1, 1, ImmB, AluAdd,   0, 0, 0, 0, WbAlu);

        // Illegal opcode: sticky TRAP with no strobes, mem_ready ignored.
        bus.mem_rdata = 32'h0000_007F;
        bus.mem_ready = 1'b1;
        tick();
        chk("trap_decode_state", bus.state, StDecode);
        tick();
        chk("trap_state", bus.state, StTrap);
        chk("trap_illegal", bus.illegal, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("trap_hold_state", bus.state, StTrap);
            chk("trap_mem_req", bus.mem_req, 1'b0);
            chk("trap_pc_we", bus.pc_we, 1'b0);
            chk("trap_reg_we", bus.reg_we, 1'b0);
        end
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("trap_rst_state", bus.state, StFetch);
        chk("trap_rst_illegal", bus.illegal, 1'b0);
        tick();
        rst = 1'b0;

        // Reset while a load waits in MEM: abandoned, no WB strobes.
        bus.mem_rdata = 32'h0040A103;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        tick();
        chk("abort_mem_state", bus.state, StMem);
        tick();
        chk("abort_mem_wait", bus.state, StMem);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_state", bus.state, StFetch);
        chk("abort_mem_req", bus.mem_req, 1'b0);
        chk("abort_pc_we", bus.pc_we, 1'b0);
        chk("abort_reg_we", bus.reg_we, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("abort_ir", bus.inst, 32'h0000_0013);
        chk("abort_fetch_req", bus.mem_req, 1'b1);

        run_instr("addi2", 32'h00500093, 1, 0, 0, 0, 1, ImmI, AluAdd,   0, 0, 0, 1, WbAlu);
        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
